// File: rtl/cfg_loader_pkg.sv
// cfg_loader_pkg: shared state encoding and sizing helpers for the PE config loader.
package cfg_loader_pkg;
  localparam int DEF_WORD_W = 32;
  typedef enum logic [2:0] {IDLE, CLR, FETCH, SHIFT_LO, SHIFT_HI, FIN} state_t;
  function automatic int words_for(input int chain_len, input int word_w = DEF_WORD_W);
    return (chain_len + word_w - 1) / word_w;
  endfunction
endpackage

// File: rtl/cfg_readback_packer.sv
// cfg_readback_packer: collects serial chain-tail bits into LSB-first words, flushing a zero-padded partial word on demand.
module cfg_readback_packer
  import cfg_loader_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              sample,
  input  logic              flush,
  input  logic              din,
  output logic [WORD_W-1:0] ro_data,
  output logic              ro_valid
);
  localparam int IW = WORD_W > 1 ? $clog2(WORD_W) : 1;
  logic [WORD_W-1:0] acc, nxt;
  logic [IW-1:0] idx;
  logic emit;
  always_comb begin
    nxt = acc;
    nxt[idx] = din;
  end
  assign emit = flush || idx == IW'(WORD_W - 1);
  // acc is cleared after every emit, so a flushed partial word is already zero-padded
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      idx <= '0;
      ro_data <= '0;
      ro_valid <= 1'b0;
    end else begin
      ro_valid <= sample && emit;
      if (clr) begin
        acc <= '0;
        idx <= '0;
      end else if (sample) begin
        acc <= emit ? '0 : nxt;
        idx <= emit ? '0 : idx + 1'b1;
        if (emit) ro_data <= nxt;
      end
    end
  end
endmodule

// File: rtl/pe_config_loader.sv
// pe_config_loader: serialises config words into a PE shift chain (2 clk per bit) and returns the bits leaving its tail.
module pe_config_loader
  import cfg_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W = DEF_WORD_W,
  parameter int CLR_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              config_in_o,
  output logic              config_clk_o,
  output logic              config_reset_o,
  input  logic              config_out_i,
  output logic [WORD_W-1:0] ro_data,
  output logic              ro_valid,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(words_for(CHAIN_LEN, WORD_W) * WORD_W + 1);
  localparam int IW = WORD_W > 1 ? $clog2(WORD_W) : 1;
  localparam int KW = $clog2(CLR_CYCLES + 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [IW-1:0] bidx;
  logic [KW-1:0] clr_cnt;
  logic [WORD_W-1:0] sreg;
  logic last_bit;
  assign last_bit = cnt == CW'(CHAIN_LEN - 1);
  assign s_ready = state == FETCH;
  assign busy = state != IDLE;
  assign done = state == FIN;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     nxt = start ? CLR : IDLE;
      CLR:      nxt = clr_cnt == KW'(CLR_CYCLES - 1) ? FETCH : CLR;
      FETCH:    nxt = s_valid ? SHIFT_LO : FETCH;
      SHIFT_LO: nxt = SHIFT_HI;
      SHIFT_HI: nxt = last_bit ? FIN : bidx == IW'(WORD_W - 1) ? FETCH : SHIFT_LO;
      FIN:      nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end
  // chain pins are registered from the next state so they change only on clk edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bidx <= '0;
      clr_cnt <= '0;
      sreg <= '0;
      config_in_o <= 1'b0;
      config_clk_o <= 1'b0;
      config_reset_o <= 1'b0;
    end else begin
      state <= nxt;
      config_reset_o <= nxt == CLR;
      config_clk_o <= nxt == SHIFT_HI;
      if (nxt == SHIFT_LO) config_in_o <= state == FETCH ? s_data[0] : sreg[0];
      clr_cnt <= state == CLR ? clr_cnt + 1'b1 : '0;
      if (state == IDLE) cnt <= '0;
      if (state == FETCH && s_valid) begin
        sreg <= s_data;
        bidx <= '0;
      end
      if (state == SHIFT_LO) sreg <= sreg >> 1;
      if (state == SHIFT_HI) begin
        cnt <= cnt + 1'b1;
        bidx <= bidx + 1'b1;
      end
    end
  end
  cfg_readback_packer #(.WORD_W(WORD_W)) u_packer (
    .clk(clk),
    .reset(reset),
    .clr(state == CLR),
    .sample(state == SHIFT_LO),
    .flush(last_bit),
    .din(config_out_i),
    .ro_data(ro_data),
    .ro_valid(ro_valid)
  );
endmodule

// File: tb/tb_pe_config_loader.sv
// tb_pe_config_loader: random loads into behavioural chain models (CHAIN_LEN 64 and 40) with a readback scoreboard.
module tb_pe_config_loader;
  logic clk = 0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;

  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int CL = g ? 40 : 64;
    localparam int NW = (CL + 31) / 32;
    localparam int CLRC = 4;
    logic reset = 1, start = 0, s_valid = 0, s_ready;
    logic [31:0] s_data = '0, ro_data;
    logic config_in_o, config_clk_o, config_reset_o, ro_valid, busy, done;
    logic [CL-1:0] chain = '0;
    logic [31:0] sb[$];
    int edges = 0, rst_cyc = 0, dones = 0;
    bit fin_flag = 0;

    pe_config_loader #(.CHAIN_LEN(CL), .WORD_W(32), .CLR_CYCLES(CLRC)) dut (
      .clk(clk), .reset(reset), .start(start), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .config_in_o(config_in_o), .config_clk_o(config_clk_o),
      .config_reset_o(config_reset_o), .config_out_i(chain[0]), .ro_data(ro_data),
      .ro_valid(ro_valid), .busy(busy), .done(done)
    );

    // the model keeps its cells across config_reset so a second load reads back the first
    always @(posedge config_clk_o) begin
      chain <= {config_in_o, chain[CL-1:1]};
      edges++;
    end
    always @(negedge clk) begin
      if (config_reset_o) rst_cyc++;
      if (done) dones++;
      if (ro_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL CL%0d ro_unexpected: got ro_data %0h with no word expected", CL, ro_data);
        end else ck("ro_data", ro_data, sb.pop_front());
      end
    end

    task automatic ck(input string n, input logic [63:0] a, input logic [63:0] e);
      check($sformatf("CL%0d %s", CL, n), a, e);
    endtask

    task automatic run_load(input logic [NW*32-1:0] stream, input int stall_w, input int restart_cyc, input int abort_cyc);
      logic [CL-1:0] snap;
      logic [31:0] word;
      int e0, r0, d0, se0, wi, hold, dc;
      bit fin;
      snap = chain;
      se0 = 0; wi = 0; hold = 0; dc = 0; fin = 0;
      if (abort_cyc == 0)
        for (int w = 0; w < NW; w++) begin
          word = '0;
          for (int b = 0; b < 32; b++) if (w * 32 + b < CL) word[b] = snap[w*32+b];
          sb.push_back(word);
        end
      @(negedge clk);
      start = 1;
      e0 = edges; r0 = rst_cyc; d0 = dones;
      for (int cyc = 1; cyc < 1000 && !fin; cyc++) begin
        @(negedge clk);
        start = (cyc == restart_cyc);
        s_valid = 0;
        if (abort_cyc > 0 && cyc >= abort_cyc && config_clk_o) begin
          reset = 1;
          #1;
          ck("abort_chain_pins", {config_clk_o, config_reset_o}, 0);
          @(negedge clk);
          ck("abort_outputs", {busy, s_ready, done, ro_valid, config_in_o, config_clk_o, config_reset_o}, 0);
          ck("abort_ro_data", ro_data, 0);
          reset = 0;
          return;
        end
        if (s_ready && wi < NW) begin
          if (wi == stall_w && hold < 20) begin
            if (hold == 0) se0 = edges;
            hold++;
          end else begin
            if (wi == stall_w) ck("stall_no_edges", edges - se0, 0);
            s_valid = 1;
            s_data = stream[wi*32 +: 32];
            wi++;
          end
        end
        if (done) begin
          fin = 1;
          dc = cyc;
        end
      end
      s_valid = 0;
      if (!fin) begin
        checks++;
        errors++;
        $display("FAIL CL%0d done_timeout: no done within 1000 cycles", CL);
        return;
      end
      ck("done_cycle", dc, CLRC + NW + 2 * CL + 1 + (stall_w >= 0 ? 20 : 0));
      repeat (2) @(negedge clk);
      ck("busy_after", busy, 0);
      ck("done_pulses", dones - d0, 1);
      ck("clk_edges", edges - e0, CL);
      ck("reset_cycles", rst_cyc - r0, CLRC);
      ck("chain", chain, stream[CL-1:0]);
      ck("rb_pending", sb.size(), 0);
    endtask

    initial begin
      repeat (3) @(negedge clk);
      ck("reset_outputs", {busy, s_ready, done, ro_valid, config_in_o, config_clk_o, config_reset_o}, 0);
      ck("reset_ro_data", ro_data, 0);
      reset = 0;
      run_load(g ? {32'h0000_00AB, 32'hFFFF_FFFF} : {32'h8000_00FF, 32'hA5A5_0001}, -1, 0, 0);
      run_load({$urandom, $urandom}, -1, 30, 0);
      run_load({$urandom, $urandom}, 1, 0, 0);
      run_load({$urandom, $urandom}, -1, 0, 20);
      repeat (3) run_load({$urandom, $urandom}, -1, 0, 0);
      fin_flag = 1;
    end
  end

  initial begin
    for (int i = 0; i < 20000 && !(cfg[0].fin_flag && cfg[1].fin_flag); i++) @(negedge clk);
    if (!(cfg[0].fin_flag && cfg[1].fin_flag)) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: stimulus did not complete");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
